// File: rtl/audio_pkg.sv
// Shared constants and frame type for the stereo audio sample FIFO.
package audio_pkg;

  localparam int unsigned SAMPLE_W_DEF   = 24;
  localparam int unsigned UNDERRUN_CNT_W = 16;

  typedef struct packed {
    logic [SAMPLE_W_DEF-1:0] left;
    logic [SAMPLE_W_DEF-1:0] right;
  } stereo_frame_t;

endpackage

// File: rtl/stereo_frame_ram.sv
// Simple dual-port frame storage: one write port, one registered read port.
// Storage is not reset; only the read register clears on reset.
module stereo_frame_ram
  import audio_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        we,
  input  logic [$clog2(DEPTH)-1:0]    waddr,
  input  logic [2*SAMPLE_W-1:0]       wdata,
  input  logic                        re,
  input  logic [$clog2(DEPTH)-1:0]    raddr,
  output logic [2*SAMPLE_W-1:0]       rdata
);

  logic [2*SAMPLE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Write-first on address collision: a pop at level 1 with a coincident
  // write must present the frame being written as the new head.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/audio_sample_fifo.sv
// Stereo frame FIFO: frames written as {left,right}, popped one cycle after r_read.
// Optional saturating underrun counter enabled by macro AUDIO_FIFO_UNDERRUN_CNT_EN.
module audio_sample_fifo
  import audio_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wr_en,
  input  logic [SAMPLE_W-1:0]        lsound_wr,
  input  logic [SAMPLE_W-1:0]        rsound_wr,
  output logic                       full,
  input  logic                       l_read,
  input  logic                       r_read,
  output logic [SAMPLE_W-1:0]        lsound_out,
  output logic [SAMPLE_W-1:0]        rsound_out,
  output logic                       empty,
  output logic                       sample_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow
`ifdef AUDIO_FIFO_UNDERRUN_CNT_EN
  ,
  output logic [UNDERRUN_CNT_W-1:0]  underrun_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);
  localparam logic [PW-1:0] FULL_LEVEL = PW'(DEPTH);

  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [PW-1:0]         wr_ptr_nx, rd_ptr_nx, level_nx;
  logic                  r_read_dly;
  logic                  pop, underrun, wr_accept, rd_load;
  logic [2*SAMPLE_W-1:0] rd_frame;
  logic                  unused_l_read;

  assign unused_l_read = l_read;

  // The output register is refreshed only when the FIFO is non-empty both
  // before and after the edge: this gives the two-cycle write-to-output
  // latency and keeps the last popped frame on the outputs once drained.
  always_comb begin
    pop       = r_read_dly && !empty;
    underrun  = r_read_dly && empty;
    wr_accept = wr_en && (!full || pop);
    wr_ptr_nx = wr_accept ? (wr_ptr + PTR_ONE) : wr_ptr;
    rd_ptr_nx = pop ? (rd_ptr + PTR_ONE) : rd_ptr;
    level_nx  = wr_ptr_nx - rd_ptr_nx;
    rd_load   = !empty && (level_nx != '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
      overflow   <= 1'b0;
      r_read_dly <= 1'b0;
    end else begin
      r_read_dly <= r_read;
      wr_ptr     <= wr_ptr_nx;
      rd_ptr     <= rd_ptr_nx;
      level      <= level_nx;
      empty      <= (level_nx == '0);
      full       <= (level_nx == FULL_LEVEL);
      if (wr_en && !wr_accept) begin
        overflow <= 1'b1;
      end
    end
  end

  assign sample_ready = !empty;

  stereo_frame_ram #(
    .DEPTH    (DEPTH),
    .SAMPLE_W (SAMPLE_W)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (wr_accept),
    .waddr   (wr_ptr[AW-1:0]),
    .wdata   ({lsound_wr, rsound_wr}),
    .re      (rd_load),
    .raddr   (rd_ptr_nx[AW-1:0]),
    .rdata   (rd_frame)
  );

  assign lsound_out = rd_frame[2*SAMPLE_W-1:SAMPLE_W];
  assign rsound_out = rd_frame[SAMPLE_W-1:0];

`ifdef AUDIO_FIFO_UNDERRUN_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underrun_cnt <= '0;
    end else if (underrun && (underrun_cnt != '1)) begin
      underrun_cnt <= underrun_cnt + UNDERRUN_CNT_W'(1);
    end
  end
`else
  logic unused_underrun;
  assign unused_underrun = underrun;
`endif

endmodule

// File: doc/audio_sample_fifo.md
AUDIO_SAMPLE_FIFO -- requirements
Module: audio_sample_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, giving the number of stereo frames stored; it SHALL be a power of two and at least 4.
REQ-002 The block SHALL have parameter SAMPLE_W, default 24, giving the sample width in bits.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1 (all logic on posedge), then reset_n input 1 (asynchronous, active-low).
REQ-004 The port list SHALL be, after clock and reset:
  wr_en  input  1  producer frame-write strobe
  lsound_wr  input  SAMPLE_W  left sample to write
  rsound_wr  input  SAMPLE_W  right sample to write
  full  output  1  no free frame slot
  l_read  input  1  consumer left-read strobe
  r_read  input  1  consumer right-read strobe, completes a frame
  lsound_out  output  SAMPLE_W  head-frame left sample
  rsound_out  output  SAMPLE_W  head-frame right sample
  empty  output  1  no stored frame
  sample_ready  output  1  equal to !empty
  level  output  $clog2(DEPTH)+1  stored frame count
  overflow  output  1  sticky flag, set when a write is dropped
  underrun_cnt  output  16  saturating underrun count (present only with the macro)

Function
REQ-005 The block SHALL store {left,right} pairs as single frames, so that one wr_en write stores both samples.
REQ-006 l_read SHALL NOT change FIFO state.
REQ-007 A frame SHALL be popped only via r_read.
REQ-008 An r_read high in cycle n, with empty=0, SHALL advance the read pointer at the end of cycle n+1 (a registered r_read_dly).
REQ-009 lsound_out and rsound_out SHALL stay stable through cycle n+1 and show the next frame from cycle n+2, so the consumer can capture one cycle after its strobe.
REQ-010 lsound_out and rsound_out SHALL be registered and SHALL always reflect the head frame while empty=0.
REQ-011 A write with empty=1 SHALL appear on the outputs 2 cycles after wr_en (one cycle for the RAM write, one for the output register).
REQ-012 wr_en with full=0 SHALL write the frame and advance the write pointer.
REQ-013 wr_en with full=1 SHALL drop the frame, leave the pointers unchanged, and set overflow.
REQ-014 A write and a pending pop in the same cycle SHALL both take effect, with level unchanged, including at full and at level=1.
REQ-015 The pointers SHALL be $clog2(DEPTH)+1 bits wide with wrap-bit full/empty detection.
REQ-016 level SHALL equal wr_ptr minus rd_ptr, mod 2·DEPTH.
REQ-017 full and empty SHALL be registered and updated in the same cycle as level.
REQ-018 An underrun SHALL be an r_read_dly with empty=1; on underrun the pointers SHALL NOT move and the outputs SHALL hold the last popped frame (zero if none popped since reset).
REQ-019 r_read high on two consecutive cycles SHALL produce two pops.
REQ-020 l_read and r_read high in the same cycle SHALL act as r_read alone.

Reset
REQ-021 With reset_n low, the pointers, level, overflow and underrun_cnt SHALL be 0.
REQ-022 With reset_n low, lsound_out and rsound_out SHALL be 0.
REQ-023 With reset_n low, empty SHALL be 1 and full and sample_ready SHALL be 0.
REQ-024 The RAM contents SHALL NOT be reset.
REQ-025 A reset asserted mid-operation SHALL discard all frames and any pending r_read_dly.
REQ-026 The first write after reset release SHALL behave as a write to an empty FIFO.

Configuration
REQ-027 With macro AUDIO_FIFO_UNDERRUN_CNT_EN defined, the underrun_cnt port SHALL exist and increment by 1 per underrun, saturating at 16'hFFFF.
REQ-028 Without AUDIO_FIFO_UNDERRUN_CNT_EN, the port and counter SHALL be absent and underrun behaviour otherwise identical.

Structure
REQ-029 Package audio_pkg SHALL hold SAMPLE_W_DEF=24, the typedef stereo_frame_t {left,right}, and the constant UNDERRUN_CNT_W=16.
REQ-030 Sub-module stereo_frame_ram (simple dual-port, one write port, one registered read port, DEPTH×2·SAMPLE_W) SHALL hold the storage.
REQ-031 Pointer, flag and counter logic SHALL live in audio_sample_fifo.

Verification
REQ-032 Reset, then write frame L=24'h000001 R=24'h800001 -> empty=0 and level=1 two cycles later, with lsound_out=24'h000001 and rsound_out=24'h800001.
REQ-033 Write 16 frames (DEPTH=16) -> full=1, level=16; a 17th wr_en -> dropped, overflow=1, level=16.
REQ-034 With 3 frames stored, pulse r_read in cycle n -> outputs unchanged in n+1 and showing the second frame in n+2, level=2.
REQ-035 Full FIFO, wr_en coincident with a pop -> level stays 16 and the new frame is read out last.
REQ-036 Empty FIFO, 3 r_read pulses -> outputs hold the last frame, pointers unchanged, underrun_cnt=3 with the macro and no port without it.
REQ-037 Reset asserted with level=5 -> level=0, empty=1 and outputs 0 at once; after release, one write gives level=1.
